uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_bps.sv | 36 +++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: data width, baud counter width and the
// receive FSM state encoding. The PARITY state exists only when
// UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned IDX_W  = 3;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/uart_rx_bps.sv
// Baud-rate timing for the UART receiver.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   run        - counter advances while high, held at 0 while low
//   half_tick  - counter is at HALF (mid start bit)
//   full_tick  - counter is at DIV (mid data/parity/stop bit); counter wraps
module rx_bps
  import uart_pkg::*;
#(
  parameter int unsigned DIV  = 867,
  parameter int unsigned HALF = 433
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic half_tick,
  output logic full_tick
);

  logic [CNT_W-1:0] cnt;

  // Free-running bit-period counter, cleared whenever run drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || cnt == CNT_W'(DIV)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign half_tick = (cnt == CNT_W'(HALF));
  assign full_tick = (cnt == CNT_W'(DIV));

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, optional even parity.
// Optional feature macro: UART_RX_PARITY_EN (adds one even-parity bit).
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   rxd         - serial line, idle high, asynchronous to clk
//   rx_data     - last correctly received byte
//   rx_valid    - one-cycle pulse when rx_data is updated
//   frame_err   - one-cycle pulse when the stop bit is sampled low
//   parity_err  - one-cycle pulse on parity mismatch (0 without parity)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BPS      = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err
);

  // Clamp so a very low clock/baud ratio still gives a non-zero period
  localparam int unsigned RATIO = CLK_FREQ / BPS;
  localparam int unsigned DIV   = (RATIO > 1) ? RATIO - 1 : 1;
  localparam int unsigned HALF  = DIV / 2;

  state_t              state;
  logic                rxd_meta;
  logic                rxd_sync;
  logic                rxd_prev;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shift;
  logic                run_c;
  logic                half_tick;
  logic                full_tick;

  // Two-flop synchronizer plus one history flop for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Dropping run for one cycle at the start-bit midpoint re-zeroes the
  // counter so data bits are sampled a full period later, mid-bit.
  assign run_c = (state != IDLE) && !(state == START && half_tick);

  rx_bps #(
    .DIV  (DIV),
    .HALF (HALF)
  ) u_bps (
    .clk       (clk),
    .rst       (rst),
    .run       (run_c),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // Receive FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
            state   <= START;
          end
        end
        START: begin
          // A high line at mid start bit is a glitch
          if (half_tick) begin
            state <= rxd_sync ? IDLE : DATA;
          end
        end
        DATA: begin
          if (full_tick) begin
            shift   <= {rxd_sync, shift[DATA_W-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (full_tick) begin
            par_bad <= rxd_sync ^ (^shift);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Back to IDLE at mid stop bit so the next start edge is seen
          if (full_tick) begin
            state <= IDLE;
            if (!rxd_sync) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
`endif
            end else begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at default parameters
// (100 MHz clock, 115200 baud, 868 clocks per bit).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned BIT_CYC = 868;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;

  int errors = 0;
  int checks = 0;

  int         valid_cnt;
  int         ferr_cnt;
  int         perr_cnt;
  int         both_cnt;
  logic [7:0] got[$];
  time        valid_t;
  time        start_t;
  logic       bad_par = 1'b0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got.push_back(rx_data);
      valid_t = $time;
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  task automatic clear_mon();
    valid_cnt = 0;
    ferr_cnt  = 0;
    perr_cnt  = 0;
    both_cnt  = 0;
    got.delete();
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CYC) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    start_t = $time;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`endif
    send_bit(stop_b);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_basic();
    time lat;
    clear_mon();
    send_frame(8'h55, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    lat = valid_t - start_t;
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL basic_valid_cnt: got %0d expected 1", valid_cnt); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL basic_data: got %h expected 55", rx_data); end
    checks++; if (ferr_cnt != 0 || perr_cnt != 0) begin errors++; $display("FAIL basic_err: got ferr=%0d perr=%0d expected 0/0", ferr_cnt, perr_cnt); end
    // ~9.5 bit times (82460 ns) plus synchronizer delay
    checks++; if (lat < 82400 || lat > 82600) begin errors++; $display("FAIL basic_latency: got %0t expected 82400..82600 ns", lat); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rxd = 1'b0;
    repeat (200) @(posedge clk);
    rxd = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    checks++; if (valid_cnt != 0 || ferr_cnt != 0) begin errors++; $display("FAIL glitch_pulse: got valid=%0d ferr=%0d expected 0/0", valid_cnt, ferr_cnt); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE); end
    send_frame(8'hA3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL glitch_next_cnt: got %0d expected 1", valid_cnt); end
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL glitch_next_data: got %h expected a3", rx_data); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    repeat (BIT_CYC / 2) @(posedge clk);
    #1;
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_cnt: got %0d expected 1", ferr_cnt); end
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cnt); end
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL ferr_data_held: got %h expected a3", rx_data); end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL ferr_both: got %0d expected 0", both_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", got.size());
    end else if (got[0] !== 8'hA3 || got[1] !== 8'h0F) begin
      errors++; $display("FAIL b2b_data: got %h %h expected a3 0f", got[0], got[1]);
    end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (BIT_CYC / 2) @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
    rst = 1'b0;
    repeat (BIT_CYC / 2) @(posedge clk);
    checks++; if (valid_cnt != 0 || ferr_cnt != 0) begin errors++; $display("FAIL rstmid_abort: got valid=%0d ferr=%0d expected 0/0", valid_cnt, ferr_cnt); end
    send_frame(8'h12, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (valid_cnt != 1 || ferr_cnt != 0 || perr_cnt != 0) begin errors++; $display("FAIL rstmid_pulses: got valid=%0d ferr=%0d perr=%0d expected 1/0/0", valid_cnt, ferr_cnt, perr_cnt); end
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL rstmid_data2: got %h expected 12", rx_data); end
  endtask

  task automatic test_break();
    clear_mon();
    rxd = 1'b0;
    repeat (BIT_CYC * 12) @(posedge clk);
    #1;
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL break_ferr: got %0d expected 1", ferr_cnt); end
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL break_valid: got %0d expected 0", valid_cnt); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL break_state: got %0d expected %0d", dut.state, IDLE); end
    rxd = 1'b1;
    repeat (BIT_CYC / 2) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL break_data_held: got %h expected 12", rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    bad_par = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (perr_cnt != 1) begin errors++; $display("FAIL par_perr: got %0d expected 1", perr_cnt); end
    checks++; if (valid_cnt != 0 || ferr_cnt != 0) begin errors++; $display("FAIL par_other: got valid=%0d ferr=%0d expected 0/0", valid_cnt, ferr_cnt); end
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL par_data_held: got %h expected 12", rx_data); end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
